mem_arbiter: RTL and testbench

- Shares the single word-granular external memory port between the instruction cache (port I) and the data cache (port D).
- Sits between both cache instances and the memory model.
- Grants one cache at a time and holds the grant across a locked line fill or write-through sequence.
- Tracks outstanding reads so each `i_mem_valid` beat is routed to the cache that issued the read.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_rd_tracker.sv | 38 +++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT_I,
        ARB_GNT_D
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int unsigned MAX_RD_DEF = 4;
    localparam int unsigned CW_DEF     = 3;

    function automatic state_t gnt_state(input logic port);
        return (port == PORT_D) ? ARB_GNT_D : ARB_GNT_I;
    endfunction

endpackage

// File: rtl/mem_arb_rd_tracker.sv
// Outstanding-read counter: counts accepted reads not yet returned by memory.
module mem_arb_rd_tracker #(
    parameter int unsigned MAX_RD = 4,
    parameter int unsigned CW     = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          rd_accept_i,
    input  logic          mem_valid_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] cnt_next_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_eff;
    logic          ret;

    // A return with nothing outstanding is stray and must not underflow.
    assign ret     = mem_valid_i && (cnt_q != '0);
    assign empty_o = (cnt_q == '0);

    always_comb begin
        cnt_eff    = cnt_q - {{(CW-1){1'b0}}, ret};
        full_o     = (cnt_eff == CW'(MAX_RD));
        cnt_d      = cnt_q + {{(CW-1){1'b0}}, rd_accept_i} - {{(CW-1){1'b0}}, ret};
        cnt_next_o = cnt_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache and D-cache with lockable grants.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is D-priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_RD = MAX_RD_DEF,
    parameter int unsigned CW     = CW_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pi_addr,
    input  logic        i_pi_ren,
    input  logic        i_pi_wen,
    input  logic [31:0] i_pi_wdata,
    input  logic        i_pi_lock,
    output logic        o_pi_ready,
    output logic [31:0] o_pi_rdata,
    output logic        o_pi_valid,
    input  logic [31:0] i_pd_addr,
    input  logic        i_pd_ren,
    input  logic        i_pd_wen,
    input  logic [31:0] i_pd_wdata,
    input  logic        i_pd_lock,
    output logic        o_pd_ready,
    output logic [31:0] o_pd_rdata,
    output logic        o_pd_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid
);

    state_t state_q, state_d;
    logic   last_q, last_d;

    logic          gnt_i, gnt_d, owned;
    logic          sel_ren, sel_wen, sel_lock;
    logic [31:0]   sel_addr, sel_wdata;
    logic          beat_ready, rd_ret;
    logic          req_i, req_d, tie_port;
    logic          rd_full, rd_empty;
    logic [CW-1:0] rd_cnt_next;

    assign gnt_i = (state_q == ARB_GNT_I);
    assign gnt_d = (state_q == ARB_GNT_D);
    assign owned = gnt_i || gnt_d;

    always_comb begin
        sel_ren   = 1'b0;
        sel_wen   = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        unique case (state_q)
            ARB_GNT_I: begin
                sel_ren   = i_pi_ren;
                sel_wen   = i_pi_wen;
                sel_lock  = i_pi_lock;
                sel_addr  = i_pi_addr;
                sel_wdata = i_pi_wdata;
            end
            ARB_GNT_D: begin
                sel_ren   = i_pd_ren;
                sel_wen   = i_pd_wen;
                sel_lock  = i_pd_lock;
                sel_addr  = i_pd_addr;
                sel_wdata = i_pd_wdata;
            end
            default: ;
        endcase
    end

    // Strobes share the ready term so memory never sees a beat we did not accept.
    assign beat_ready  = owned && i_mem_ready && !(sel_ren && rd_full);
    assign o_pi_ready  = gnt_i && beat_ready;
    assign o_pd_ready  = gnt_d && beat_ready;
    assign o_mem_addr  = sel_addr;
    assign o_mem_wdata = sel_wdata;
    assign o_mem_ren   = sel_ren && beat_ready;
    assign o_mem_wen   = sel_wen && beat_ready;

    assign rd_ret     = i_mem_valid && !rd_empty;
    assign o_pi_valid = gnt_i && rd_ret;
    assign o_pd_valid = gnt_d && rd_ret;
    assign o_pi_rdata = (gnt_i && rd_ret) ? i_mem_rdata : '0;
    assign o_pd_rdata = (gnt_d && rd_ret) ? i_mem_rdata : '0;

    mem_arb_rd_tracker #(
        .MAX_RD (MAX_RD),
        .CW     (CW)
    ) u_rd_tracker (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .rd_accept_i (o_mem_ren),
        .mem_valid_i (i_mem_valid),
        .full_o      (rd_full),
        .empty_o     (rd_empty),
        .cnt_next_o  (rd_cnt_next)
    );

    assign req_i = i_pi_ren || i_pi_wen || i_pi_lock;
    assign req_d = i_pd_ren || i_pd_wen || i_pd_lock;

`ifdef MEM_ARB_RR_EN
    assign tie_port = (last_q == PORT_D) ? PORT_I : PORT_D;
`else
    assign tie_port = PORT_D;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (req_i && req_d) begin
                    state_d = gnt_state(tie_port);
                    last_d  = tie_port;
                end else if (req_d) begin
                    state_d = ARB_GNT_D;
                    last_d  = PORT_D;
                end else if (req_i) begin
                    state_d = ARB_GNT_I;
                    last_d  = PORT_I;
                end
            end
            ARB_GNT_I, ARB_GNT_D: begin
                // Hold the grant until every read issued under it has come back.
                if (!sel_lock && (rd_cnt_next == '0)) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
            last_q  <= PORT_D;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic.
module tb_mem_arbiter;

    localparam int MAXRD = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_pi_addr, i_pi_wdata, i_pd_addr, i_pd_wdata;
    logic        i_pi_ren, i_pi_wen, i_pi_lock, i_pd_ren, i_pd_wen, i_pd_lock;
    logic        o_pi_ready, o_pi_valid, o_pd_ready, o_pd_valid;
    logic [31:0] o_pi_rdata, o_pd_rdata;
    logic        i_mem_ready, i_mem_valid;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic        o_mem_ren, o_mem_wen;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(
        .MAX_RD (4),
        .CW     (3)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_pi_addr   (i_pi_addr),
        .i_pi_ren    (i_pi_ren),
        .i_pi_wen    (i_pi_wen),
        .i_pi_wdata  (i_pi_wdata),
        .i_pi_lock   (i_pi_lock),
        .o_pi_ready  (o_pi_ready),
        .o_pi_rdata  (o_pi_rdata),
        .o_pi_valid  (o_pi_valid),
        .i_pd_addr   (i_pd_addr),
        .i_pd_ren    (i_pd_ren),
        .i_pd_wen    (i_pd_wen),
        .i_pd_wdata  (i_pd_wdata),
        .i_pd_lock   (i_pd_lock),
        .o_pd_ready  (o_pd_ready),
        .o_pd_rdata  (o_pd_rdata),
        .o_pd_valid  (o_pd_valid),
        .i_mem_ready (i_mem_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_ren   (o_mem_ren),
        .o_mem_wen   (o_mem_wen),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_valid (i_mem_valid)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lock;
    } beat_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    beat_t q_i[$];
    beat_t q_d[$];
    ret_t  mq[$];

    int   errors, checks;
    int   cyc, last_due, lat;
    bit   hold, inject;
    logic mem_rdy;
    // Reference model: owner 0 = none, 1 = I, 2 = D; cnt = reads in flight.
    int   m_owner, m_cnt, m_last;
    int   n_pi_valid, n_pd_valid, n_mem_wen;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_pi_ready"}, o_pi_ready, 1'b0);
        chk1({tag, "_pd_ready"}, o_pd_ready, 1'b0);
        chk1({tag, "_pi_valid"}, o_pi_valid, 1'b0);
        chk1({tag, "_pd_valid"}, o_pd_valid, 1'b0);
        chk32({tag, "_pi_rdata"}, o_pi_rdata, 32'h0);
        chk32({tag, "_pd_rdata"}, o_pd_rdata, 32'h0);
        chk32({tag, "_mem_addr"}, o_mem_addr, 32'h0);
        chk32({tag, "_mem_wdata"}, o_mem_wdata, 32'h0);
        chk1({tag, "_mem_ren"}, o_mem_ren, 1'b0);
        chk1({tag, "_mem_wen"}, o_mem_wen, 1'b0);
    endtask

    function automatic beat_t idle_beat();
        beat_t b;
        b.ren = 1'b0; b.wen = 1'b0; b.addr = '0; b.wdata = '0; b.lock = 1'b0;
        return b;
    endfunction

    task automatic push(input int port, input logic ren, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic lock);
        beat_t b;
        b.ren = ren; b.wen = !ren; b.addr = addr; b.wdata = wdata; b.lock = lock;
        if (port == 1) q_i.push_back(b);
        else q_d.push_back(b);
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_cnt   = 0;
        m_last  = 2;
        q_i.delete();
        q_d.delete();
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic step();
        beat_t       bi, bd, bo;
        logic        mv, rdy, e_ren, e_wen, delivered;
        logic [31:0] mrd;
        int          ret, eff, cnt_new, nxt, due;
        bit          ri, rd;
        bi = (q_i.size() > 0) ? q_i[0] : idle_beat();
        bd = (q_d.size() > 0) ? q_d[0] : idle_beat();
        mv = 1'b0; mrd = '0; delivered = 1'b0;
        if (inject) begin
            mv = 1'b1; mrd = 32'hBAD0_BAD0;
        end else if (!hold && mq.size() > 0 && mq[0].due <= cyc) begin
            mv = 1'b1; mrd = mq[0].data; delivered = 1'b1;
        end
        i_pi_ren = bi.ren; i_pi_wen = bi.wen; i_pi_addr = bi.addr;
        i_pi_wdata = bi.wdata; i_pi_lock = bi.lock;
        i_pd_ren = bd.ren; i_pd_wen = bd.wen; i_pd_addr = bd.addr;
        i_pd_wdata = bd.wdata; i_pd_lock = bd.lock;
        i_mem_valid = mv; i_mem_rdata = mrd; i_mem_ready = mem_rdy;
        #1;
        bo  = (m_owner == 1) ? bi : (m_owner == 2) ? bd : idle_beat();
        ret = (mv && m_cnt > 0) ? 1 : 0;
        eff = m_cnt - ret;
        rdy = (m_owner != 0) && mem_rdy && !(bo.ren && eff >= MAXRD);
        e_ren = bo.ren && rdy;
        e_wen = bo.wen && rdy;
        chk1("pi_ready", o_pi_ready, m_owner == 1 && rdy);
        chk1("pd_ready", o_pd_ready, m_owner == 2 && rdy);
        chk1("pi_valid", o_pi_valid, m_owner == 1 && ret == 1);
        chk1("pd_valid", o_pd_valid, m_owner == 2 && ret == 1);
        chk32("pi_rdata", o_pi_rdata, (m_owner == 1 && ret == 1) ? mrd : 32'h0);
        chk32("pd_rdata", o_pd_rdata, (m_owner == 2 && ret == 1) ? mrd : 32'h0);
        chk32("mem_addr", o_mem_addr, bo.addr);
        chk32("mem_wdata", o_mem_wdata, bo.wdata);
        chk1("mem_ren", o_mem_ren, e_ren);
        chk1("mem_wen", o_mem_wen, e_wen);
        if (o_pi_valid) n_pi_valid++;
        if (o_pd_valid) n_pd_valid++;
        if (o_mem_wen) n_mem_wen++;
        if (delivered) void'(mq.pop_front());
        if (e_ren) begin
            ret_t r;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.due = due; r.data = $urandom;
            mq.push_back(r);
        end
        if (e_ren || e_wen) begin
            if (m_owner == 1) void'(q_i.pop_front());
            else void'(q_d.pop_front());
        end
        cnt_new = m_cnt + (e_ren ? 1 : 0) - ret;
        if (m_owner == 0) begin
            ri = bi.ren || bi.wen || bi.lock;
            rd = bd.ren || bd.wen || bd.lock;
            if (ri && rd) begin
`ifdef MEM_ARB_RR_EN
                nxt = (m_last == 2) ? 1 : 2;
`else
                nxt = 2;
`endif
            end else if (rd) nxt = 2;
            else if (ri) nxt = 1;
            else nxt = 0;
            if (nxt != 0) m_last = nxt;
        end else if (!bo.lock && cnt_new == 0) begin
            nxt = 0;
        end else begin
            nxt = m_owner;
        end
        m_owner = nxt;
        m_cnt   = cnt_new;
        inject  = 1'b0;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge i_clk);
            step();
        end
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; last_due = 0; lat = 2;
        hold = 0; inject = 0; mem_rdy = 1'b1;
        n_pi_valid = 0; n_pd_valid = 0; n_mem_wen = 0;
        model_reset();
        i_rst = 1'b1;
        i_pi_addr = 32'h40; i_pi_ren = 1'b1; i_pi_wen = 1'b0; i_pi_wdata = '0; i_pi_lock = 1'b1;
        i_pd_addr = 32'h80; i_pd_ren = 1'b0; i_pd_wen = 1'b1; i_pd_wdata = '1; i_pd_lock = 1'b0;
        i_mem_ready = 1'b1; i_mem_valid = 1'b1; i_mem_rdata = 32'h1234_5678;
        #2;
        chk_zero("reset");
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        step();
        run(2);

        // Locked I-cache fill; D write arrives mid-fill and must wait.
        n_pi_valid = 0;
        for (int k = 0; k < 4; k++) push(1, 1'b1, 32'h100 + 32'(4 * k), '0, k < 3);
        run(3);
        push(2, 1'b0, 32'h300, 32'h1234_5678, 1'b0);
        run(20);
        chk32("fill_valid_count", 32'(n_pi_valid), 32'd4);

        // Two simultaneous ties in IDLE.
        push(1, 1'b1, 32'h400, '0, 1'b0);
        push(2, 1'b1, 32'h500, '0, 1'b0);
        run(12);
        push(1, 1'b1, 32'h404, '0, 1'b0);
        push(2, 1'b1, 32'h504, '0, 1'b0);
        run(12);

        // Single unlocked write: exactly one strobe.
        n_mem_wen = 0;
        push(2, 1'b0, 32'h200, 32'hDEAD_BEEF, 1'b0);
        run(6);
        chk32("write_strobe_count", 32'(n_mem_wen), 32'd1);

        // Five locked reads with memory stalled, then let returns flow.
        hold = 1;
        for (int k = 0; k < 5; k++) push(2, 1'b1, 32'h600 + 32'(4 * k), '0, k < 4);
        run(8);
        hold = 0;
        run(12);

        // Reset with two reads in flight; their late returns must be ignored.
        hold = 1;
        push(2, 1'b1, 32'h700, '0, 1'b1);
        push(2, 1'b1, 32'h704, '0, 1'b0);
        run(4);
        @(negedge i_clk);
        #3 i_rst = 1'b1;
        #1 chk_zero("rst_mid");
        model_reset();
        cyc++;
        @(negedge i_clk);
        i_rst = 1'b0;
        step();
        n_pd_valid = 0;
        hold = 0;
        run(8);
        chk32("post_reset_valids", 32'(n_pd_valid), 32'd0);

        // Stray memory valid while D owns for a write.
        push(2, 1'b0, 32'h240, 32'hCAFE_F00D, 1'b0);
        run(1);
        inject = 1;
        n_pd_valid = 0;
        run(1);
        chk32("stray_valid", 32'(n_pd_valid), 32'd0);
        push(2, 1'b1, 32'h244, '0, 1'b0);
        run(6);

        // Random traffic.
        repeat (400) begin
            @(negedge i_clk);
            if (q_i.size() == 0 && $urandom_range(0, 2) == 0)
                push(1, 1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00}, $urandom,
                     $urandom_range(0, 3) == 0);
            if (q_d.size() == 0 && $urandom_range(0, 2) == 0)
                push(2, 1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00}, $urandom,
                     $urandom_range(0, 3) == 0);
            mem_rdy = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(1, 4);
            step();
        end
        mem_rdy = 1'b1;
        run(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
